// File: rtl/muldiv_hilo_unit_pkg.sv
// rtl/muldiv_hilo_unit_pkg.sv - op codes, FSM states and op classification for the HI/LO mul/div unit
package muldiv_hilo_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_DONE
  } md_state_e;

  // Multi-cycle ops are codes 0..3; codes 4..7 never stall the pipeline
  function automatic logic is_md_op(input logic [2:0] op);
    return !op[2];
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_div_radix2_core.sv
// rtl/muldiv_hilo_unit_div_radix2_core.sv - restoring radix-2 divider datapath, one quotient bit per enable
module div_radix2_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_next_o,
  output logic [WIDTH-1:0] rem_next_o
);

  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;

  // quot_q starts as the dividend and its MSB feeds the remainder each step
  assign shifted     = {rem_q, quot_q[WIDTH-1]};
  assign trial       = shifted - {1'b0, dvsr_q};
  assign fits        = ~trial[WIDTH];
  assign rem_next_o  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_next_o = {quot_q[WIDTH-2:0], fits};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (en_i) begin
      rem_q  <= rem_next_o;
      quot_q <= quot_next_o;
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - EX-stage multi-cycle multiply/divide unit owning the HI/LO registers
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W     = $clog2(WIDTH) + 1;
  localparam int MUL_ITERS = WIDTH / MUL_BITS;

  md_state_e            state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d, rem_neg_q, rem_neg_d, dz_q, dz_d;
  logic                 div_load, div_en;

  logic [WIDTH-1:0]     mag_a, mag_b, quot_next, rem_next, quot_signed, rem_signed;
  logic [2*WIDTH-1:0]   mul_digit, acc_step, prod_signed;
  logic                 sign_flip;

  // Signed ops run on magnitudes; the most negative value maps onto itself as unsigned
  assign mag_a     = (is_signed_op(op_i) && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
  assign mag_b     = (is_signed_op(op_i) && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
  assign sign_flip = is_signed_op(op_i) && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);

  assign mul_digit   = (2*WIDTH)'(mplier_q[MUL_BITS-1:0]);
  assign acc_step    = acc_q + mcand_q * mul_digit;
  assign prod_signed = neg_q ? -acc_step : acc_step;
  assign quot_signed = neg_q ? -quot_next : quot_next;
  assign rem_signed  = rem_neg_q ? -rem_next : rem_next;

  div_radix2_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .en_i       (div_en),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quot_next_o(quot_next),
    .rem_next_o (rem_next)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    div_load  = 1'b0;
    div_en    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !annul_i) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, mag_a};
              mplier_d = mag_b;
              neg_d    = sign_flip;
              cnt_d    = '0;
              state_d  = MD_MUL;
            end
            OP_DIV, OP_DIVU: begin
              cnt_d = '0;
              dz_d  = (src_b_i == '0);
              if (src_b_i == '0) begin
                hi_d    = src_a_i;
                lo_d    = '1;
                state_d = MD_DONE;
              end else begin
                div_load  = 1'b1;
                neg_d     = sign_flip;
                rem_neg_d = is_signed_op(op_i) && src_a_i[WIDTH-1];
                state_d   = MD_DIV;
              end
            end
            OP_MTHI: hi_d = src_a_i;
            OP_MTLO: lo_d = src_a_i;
            default: ;
          endcase
        end
      end
      MD_MUL: begin
        if (annul_i) begin
          state_d = MD_IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
            hi_d    = prod_signed[2*WIDTH-1:WIDTH];
            lo_d    = prod_signed[WIDTH-1:0];
            dz_d    = 1'b0;
            state_d = MD_DONE;
          end
        end
      end
      MD_DIV: begin
        if (annul_i) begin
          state_d = MD_IDLE;
        end else begin
          div_en = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_d    = rem_signed;
            lo_d    = quot_signed;
            state_d = MD_DONE;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
    end
  end

  assign busy_o     = (state_q == MD_MUL) || (state_q == MD_DIV) ||
                      ((state_q == MD_IDLE) && start_i && !annul_i && is_md_op(op_i));
  assign done_o     = (state_q == MD_DONE);
  assign div_zero_o = (state_q == MD_DONE) && dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - scoreboard bench for muldiv_hilo_unit at 32-bit and 16-bit configurations
module tb_muldiv_hilo_unit;
  import muldiv_hilo_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, annul = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, dz16;
  logic [15:0] hi16, lo16;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t exp16_q[$];

  muldiv_hilo_unit #(.WIDTH(32), .MUL_BITS(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .src_a_i(a), .src_b_i(b),
    .annul_i(annul), .busy_o(busy), .done_o(done), .div_zero_o(dz), .hi_o(hi), .lo_o(lo)
  );

  muldiv_hilo_unit #(.WIDTH(16), .MUL_BITS(2)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .op_i(op16), .src_a_i(a16), .src_b_i(b16),
    .annul_i(1'b0), .busy_o(busy16), .done_o(done16), .div_zero_o(dz16), .hi_o(hi16), .lo_o(lo16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_zero", 64'(dz), 64'(e.dz));
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done16) begin
      if (exp16_q.size() == 0) begin
        check("unexpected_done16", 64'd1, 64'd0);
      end else begin
        e = exp16_q.pop_front();
        check("done16_cycle", 64'(cyc), 64'(e.cyc));
        check("hi16", 64'(hi16), 64'(e.hi));
        check("lo16", 64'(lo16), 64'(e.lo));
        check("div_zero16", 64'(dz16), 64'(e.dz));
      end
    end
  end

  // Issues one op, expects done at cycle lat, checks busy for cycles 0..lat
  task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int poke);
    start = 1'b1;
    op = o;
    a = va;
    b = vb;
    exp_q.push_back('{hi: ehi, lo: elo, dz: edz, cyc: cyc + lat});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check("busy", 64'(busy), 64'(k < lat));
      tick();
      start = (poke != 0) && (k + 1 == poke);
      if (start) begin
        op = OP_MTHI;
        a = 32'hDEAD_BEEF;
      end
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    check("rst_hi16", 64'(hi16), 64'd0);
    tick();

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         9, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 4);
    run_op(OP_MULT,  32'd7,         32'hFFFF_FFFA, 9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,33, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE,33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(OP_DIVU,  32'd100,       32'd7,        33, 32'h0000_0002, 32'h0000_000E, 1'b0, 0);
    run_op(OP_DIVU,  32'h0000_1234, 32'd0,         1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0);

    // Annul a divide at cycle 10: no done, HI/LO untouched
    start = 1'b1; op = OP_DIVU; a = 32'h1000; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    @(negedge clk);
    check("annul_busy", 64'(busy), 64'd0);
    check("annul_hi", 64'(hi), 64'h1234);
    check("annul_lo", 64'(lo), 64'hFFFF_FFFF);
    tick();
    repeat (30) tick();

    // MTHI writes next cycle without stalling
    start = 1'b1; op = OP_MTHI; a = 32'h0000_ABCD;
    @(negedge clk);
    check("mthi_busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h0000_ABCD);
    check("mthi_lo", 64'(lo), 64'hFFFF_FFFF);
    check("mthi_done", 64'(done), 64'd0);
    tick();

    // MTLO with annul and a reserved op are both ignored
    start = 1'b1; op = OP_MTLO; a = 32'h5555_5555; annul = 1'b1;
    @(negedge clk);
    check("annul_start_busy", 64'(busy), 64'd0);
    tick();
    annul = 1'b0; op = 3'd6; a = 32'h7777_7777;
    @(negedge clk);
    check("mtlo_annul_lo", 64'(lo), 64'hFFFF_FFFF);
    check("rsvd_busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("rsvd_hi", 64'(hi), 64'h0000_ABCD);
    check("rsvd_lo", 64'(lo), 64'hFFFF_FFFF);
    tick();

    // Reset in the middle of a multiply
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    tick();
    repeat (12) tick();

    // 16-bit instance, two multiplier bits per cycle
    start16 = 1'b1; op16 = OP_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF;
    exp16_q.push_back('{hi: 32'h0000_FFFE, lo: 32'h0000_0001, dz: 1'b0, cyc: cyc + 9});
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check("busy16", 64'(busy16), 64'(k < 9));
      tick();
      start16 = 1'b0;
    end

    repeat (3) tick();
    check("pending", 64'(exp_q.size()), 64'd0);
    check("pending16", 64'(exp16_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
